// File: rtl/upload_pkg.sv
// Shared definitions for the HPS upload reader: FSM state encoding and the
// byte returned for addresses beyond the valid image size.
package upload_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      LAT,
      DONE
   } state_t;

   localparam logic [7:0] FILL_BYTE = 8'hFF;

endpackage

// File: rtl/ioctl_upload_reader_if.sv
// Upload-side and RAM-port signals of the upload reader. The reader is the
// slave; hps_io plus the RAM arbiter form the master side.
interface ioctl_upload_reader_if #(
   parameter int ADDR_W = 14
);

   logic              ul_upload;
   logic [7:0]        ul_index;
   logic              ul_rd;
   logic [ADDR_W-1:0] ul_addr;
   logic [7:0]        ul_din;
   logic              ul_wait;

   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_gnt;
   logic [7:0]        mem_data;

   modport master (
      output ul_upload, ul_index, ul_rd, ul_addr, mem_gnt, mem_data,
      input  ul_din, ul_wait, mem_req, mem_addr
   );

   modport slave (
      input  ul_upload, ul_index, ul_rd, ul_addr, mem_gnt, mem_data,
      output ul_din, ul_wait, mem_req, mem_addr
   );

endinterface

// File: rtl/ioctl_upload_reader.sv
// Serves HPS upload reads for one ioctl index from a shared RAM read port.
// Each strobe fetches one byte (or returns the fill byte past SIZE), holding
// the HPS off with ul_wait until ul_din is valid. Also keeps a per-upload
// byte count (saturating) and a mod-256 checksum of delivered bytes.
module ioctl_upload_reader
   import upload_pkg::*;
#(
   parameter int         ADDR_W = 14,
   parameter int         SIZE   = 1024,
   parameter logic [7:0] INDEX  = 8'd4,
   parameter int         RD_LAT = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   ioctl_upload_reader_if.slave bus,
   output logic                 active,
   output logic [ADDR_W:0]      bytes_done,
   output logic [7:0]           checksum
);

   localparam logic [ADDR_W:0] SIZE_L    = (ADDR_W+1)'(SIZE);
   localparam logic [ADDR_W:0] BYTES_MAX = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] BYTES_ONE = (ADDR_W+1)'(1);
   localparam logic [1:0]      LAT_INIT  = 2'(RD_LAT - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic [1:0]        r_lat_cnt;
   logic [7:0]        r_din;
   logic              r_active;
   logic [ADDR_W:0]   r_bytes_done;
   logic [7:0]        r_checksum;

   logic w_sel;
   logic w_in_range;
   logic w_latch_addr;
   logic w_load_fill;
   logic w_load_mem;
   logic w_load_cnt;
   logic w_count;

   assign w_sel      = bus.ul_upload && (bus.ul_index == INDEX);
   assign w_in_range = ({1'b0, bus.ul_addr} < SIZE_L);

   assign bus.ul_din   = r_din;
   assign bus.mem_addr = r_addr;
   assign active       = r_active;
   assign bytes_done   = r_bytes_done;
   assign checksum     = r_checksum;

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next state, datapath strobes and handshake outputs; deselect aborts any fetch
   always_comb begin
      w_state_nxt  = r_state;
      w_latch_addr = 1'b0;
      w_load_fill  = 1'b0;
      w_load_mem   = 1'b0;
      w_load_cnt   = 1'b0;
      w_count      = 1'b0;
      bus.mem_req  = (r_state == REQ);
      bus.ul_wait  = !reset && ((bus.ul_rd && w_sel) || (r_state == REQ) || (r_state == LAT));
      if (!w_sel && (r_state != IDLE)) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.ul_rd && w_sel) begin
                  w_latch_addr = 1'b1;
                  if (w_in_range) begin
                     w_state_nxt = REQ;
                  end else begin
                     w_load_fill = 1'b1;
                     w_state_nxt = DONE;
                  end
               end
            end
            REQ: begin
               if (bus.mem_gnt) begin
                  w_load_cnt  = 1'b1;
                  w_state_nxt = LAT;
               end
            end
            LAT: begin
               if (r_lat_cnt == 2'd0) begin
                  w_load_mem  = 1'b1;
                  w_state_nxt = DONE;
               end
            end
            DONE: begin
               w_count     = 1'b1;
               w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // Address latch, latency counter, returned byte and per-upload statistics
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_addr       <= '0;
         r_lat_cnt    <= '0;
         r_din        <= FILL_BYTE;
         r_active     <= 1'b0;
         r_bytes_done <= '0;
         r_checksum   <= '0;
      end else begin
         r_active <= w_sel;
         if (w_latch_addr) r_addr <= bus.ul_addr;
         if (w_load_cnt) begin
            r_lat_cnt <= LAT_INIT;
         end else if ((r_state == LAT) && (r_lat_cnt != 2'd0)) begin
            r_lat_cnt <= r_lat_cnt - 2'd1;
         end
         if (w_load_fill) begin
            r_din <= FILL_BYTE;
         end else if (w_load_mem) begin
            r_din <= bus.mem_data;
         end
         if (w_sel && !r_active) begin
            r_bytes_done <= '0;
            r_checksum   <= '0;
         end else if (w_count) begin
            if (r_bytes_done != BYTES_MAX) r_bytes_done <= r_bytes_done + BYTES_ONE;
            r_checksum <= r_checksum + r_din;
         end
      end
   end

endmodule

// File: tb/tb_ioctl_upload_reader.sv
// Bench for ioctl_upload_reader: two instances (RD_LAT=1 and RD_LAT=3) share
// the upload stimulus and grant; each has its own pipelined RAM model.
// Expectations come from per-transaction timing windows and running sums.
module tb_ioctl_upload_reader;

   localparam int         AW  = 5;
   localparam int         SZ  = 20;
   localparam logic [7:0] IDX = 8'd4;
   localparam int         BIG = 32'h7fffffff;
   localparam int         SAT = 32;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic          upl  = 1'b0;
   logic [7:0]    idx  = 8'd0;
   logic          rd   = 1'b0;
   logic [AW-1:0] addr = '0;
   logic          gnt  = 1'b0;
   logic [7:0]    ram [0:31];
   logic [7:0]    junk = 8'h00;

   ioctl_upload_reader_if #(.ADDR_W(AW)) bus0 ();
   ioctl_upload_reader_if #(.ADDR_W(AW)) bus1 ();

   assign bus0.ul_upload = upl;  assign bus1.ul_upload = upl;
   assign bus0.ul_index  = idx;  assign bus1.ul_index  = idx;
   assign bus0.ul_rd     = rd;   assign bus1.ul_rd     = rd;
   assign bus0.ul_addr   = addr; assign bus1.ul_addr   = addr;
   assign bus0.mem_gnt   = gnt;  assign bus1.mem_gnt   = gnt;

   logic          act   [2];
   logic [AW:0]   bd    [2];
   logic [7:0]    cs    [2];
   logic [7:0]    o_din [2];
   logic          o_wait[2];
   logic          o_req [2];
   logic [AW-1:0] o_madr[2];

   assign o_din[0]  = bus0.ul_din;   assign o_din[1]  = bus1.ul_din;
   assign o_wait[0] = bus0.ul_wait;  assign o_wait[1] = bus1.ul_wait;
   assign o_req[0]  = bus0.mem_req;  assign o_req[1]  = bus1.mem_req;
   assign o_madr[0] = bus0.mem_addr; assign o_madr[1] = bus1.mem_addr;

   ioctl_upload_reader #(.ADDR_W(AW), .SIZE(SZ), .INDEX(IDX), .RD_LAT(1)) dut0 (
      .clk(clk), .reset(reset), .bus(bus0),
      .active(act[0]), .bytes_done(bd[0]), .checksum(cs[0]));

   ioctl_upload_reader #(.ADDR_W(AW), .SIZE(SZ), .INDEX(IDX), .RD_LAT(3)) dut1 (
      .clk(clk), .reset(reset), .bus(bus1),
      .active(act[1]), .bytes_done(bd[1]), .checksum(cs[1]));

   // RAM read port: data valid exactly RD_LAT cycles after a granted request, junk otherwise
   logic          pv [2][3];
   logic [AW-1:0] pa [2][3];
   always @(posedge clk) begin
      junk <= 8'($urandom);
      for (int k = 0; k < 2; k++) begin
         pv[k][0] <= !reset && o_req[k] && gnt;
         pa[k][0] <= o_madr[k];
         for (int s = 1; s < 3; s++) begin
            pv[k][s] <= pv[k][s-1];
            pa[k][s] <= pa[k][s-1];
         end
      end
   end
   assign bus0.mem_data = pv[0][0] ? ram[pa[0][0]] : junk;
   assign bus1.mem_data = pv[1][2] ? ram[pa[1][2]] : junk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input int k, input logic [31:0] act_v, input logic [31:0] exp_v);
      n_chk++;
      if (act_v !== exp_v) begin
         n_err++;
         $display("FAIL %s[dut%0d] cycle %0d: got %0h, expected %0h", nm, k, cyc, act_v, exp_v);
      end
   endtask

   // Current transaction, written only by the stimulus process
   bit            t_act  = 1'b0;
   int            t_id   = 0;
   int            t_T    = 0;
   int            t_d    = 0;
   bit            t_in   = 1'b0;
   logic [AW-1:0] t_addr = '0;
   logic [7:0]    t_byte = 8'hFF;

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   // Cycle in which ul_din becomes valid (the FSM's DONE cycle) for instance k
   function automatic int dcyc(input int k);
      return t_T + (t_in ? (2 + t_d + lat_of(k)) : 1);
   endfunction

   // Model state, written only by the compare process
   int         last_rst   = 0;
   int         ab_id  [2] = '{-1, -1};
   int         ab_at  [2] = '{BIG, BIG};
   logic [7:0] exp_din[2] = '{8'hFF, 8'hFF};
   int         exp_bd [2] = '{0, 0};
   logic [7:0] exp_cs [2] = '{8'h00, 8'h00};
   bit         exp_act    = 1'b0;
   int         n_wait [2] = '{0, 0};
   int         n_req  [2] = '{0, 0};

   // Per-cycle compare of both instances against the window model
   always @(negedge clk) begin
      bit sel, tv, ew, er;
      int dc, ab, lim_w, lim_r;
      sel = upl && (idx == IDX);
      if (reset) begin
         for (int k = 0; k < 2; k++) begin
            chk("rst_wait", k, o_wait[k], 0);
            chk("rst_req",  k, o_req[k],  0);
            chk("rst_madr", k, o_madr[k], 0);
            chk("rst_din",  k, o_din[k],  8'hFF);
            chk("rst_act",  k, act[k],    0);
            chk("rst_bd",   k, bd[k],     0);
            chk("rst_cs",   k, cs[k],     0);
            exp_din[k] = 8'hFF;
            exp_bd[k]  = 0;
            exp_cs[k]  = 8'h00;
         end
         exp_act  = 1'b0;
         last_rst = cyc;
      end else begin
         tv = t_act && (t_T > last_rst);
         if (rd && sel) chk("protocol_strobe", 0, (tv && cyc == t_T), 1);
         for (int k = 0; k < 2; k++) begin
            dc = dcyc(k);
            if (tv && !sel && ab_id[k] != t_id && cyc <= dc) begin
               ab_id[k] = t_id;
               ab_at[k] = cyc;
            end
            ab    = (ab_id[k] == t_id) ? ab_at[k] : BIG;
            lim_w = (ab < dc - 1) ? ab : dc - 1;
            lim_r = (ab < t_T + 1 + t_d) ? ab : t_T + 1 + t_d;
            ew = tv && cyc >= t_T && cyc <= lim_w;
            er = tv && t_in && cyc >= t_T + 1 && cyc <= lim_r;
            if (tv && cyc == dc && ab >= dc) exp_din[k] = t_byte;
            chk("ul_wait",    k, o_wait[k], ew);
            chk("mem_req",    k, o_req[k],  er);
            if (er) chk("mem_addr", k, o_madr[k], t_addr);
            chk("ul_din",     k, o_din[k],  exp_din[k]);
            chk("active",     k, act[k],    exp_act);
            chk("bytes_done", k, bd[k],     exp_bd[k]);
            chk("checksum",   k, cs[k],     exp_cs[k]);
            if (o_wait[k]) n_wait[k]++;
            if (o_req[k])  n_req[k]++;
            if (sel && !exp_act) begin
               exp_bd[k] = 0;
               exp_cs[k] = 8'h00;
            end else if (tv && cyc == dc && ab == BIG) begin
               if (exp_bd[k] < SAT) exp_bd[k]++;
               exp_cs[k] = exp_cs[k] + exp_din[k];
            end
         end
         exp_act = sel;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one strobe; returns in the cycle after it with grant withheld
   task automatic strobe_only(input logic [AW-1:0] a, input int d);
      t_id++;
      t_T    = cyc;
      t_d    = d;
      t_in   = (int'(a) < SZ);
      t_addr = a;
      t_byte = t_in ? ram[a] : 8'hFF;
      t_act  = 1'b1;
      rd     = 1'b1;
      addr   = a;
      gnt    = 1'($urandom);
      step();
      rd   = 1'b0;
      addr = AW'($urandom);
      gnt  = 1'b0;
   endtask

   // Strobe, withhold grant d cycles, grant; returns in the first LAT cycle
   task automatic issue(input logic [AW-1:0] a, input int d);
      strobe_only(a, d);
      for (int i = 0; i < d; i++) begin
         gnt = 1'b0;
         step();
      end
      gnt = 1'b1;
      step();
      gnt = 1'($urandom);
   endtask

   task automatic finish_read();
      while (cyc < dcyc(1) + 1) step();
   endtask

   task automatic rd_byte(input logic [AW-1:0] a, input int d);
      issue(a, d);
      finish_read();
   endtask

   logic [7:0] lit4 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
   int bw [2];
   int br [2];

   initial begin
      for (int i = 0; i < 32; i++) ram[i] = 8'($urandom);
      for (int i = 0; i < 4; i++) ram[i] = lit4[i];
      repeat (3) step();
      reset = 1'b0;
      step();

      // Strobes for another index are ignored
      upl = 1'b1;
      idx = IDX + 8'd1;
      step();
      for (int k = 0; k < 2; k++) begin bw[k] = n_wait[k]; br[k] = n_req[k]; end
      for (int i = 0; i < 4; i++) begin
         rd = 1'b1; addr = AW'(i); step();
         rd = 1'b0; step();
      end
      for (int k = 0; k < 2; k++) begin
         chk("offidx_wait_cycles", k, n_wait[k] - bw[k], 0);
         chk("offidx_req_cycles",  k, n_req[k] - br[k],  0);
         chk("offidx_bd",          k, bd[k], 0);
         chk("offidx_cs",          k, cs[k], 0);
      end

      // Bytes 11,22,33,44 with immediate grant
      idx = IDX;
      step(); step();
      for (int k = 0; k < 2; k++) bw[k] = n_wait[k];
      for (int i = 0; i < 4; i++) begin
         rd_byte(AW'(i), 0);
         chk("seq_din", 0, o_din[0], lit4[i]);
         chk("seq_din", 1, o_din[1], lit4[i]);
      end
      for (int k = 0; k < 2; k++) begin
         chk("seq_checksum", k, cs[k], 8'hAA);
         chk("seq_bytes",    k, bd[k], 4);
      end
      chk("seq_wait_cycles", 0, n_wait[0] - bw[0], 12);
      chk("seq_wait_cycles", 1, n_wait[1] - bw[1], 20);

      // Grant withheld 5 cycles on address 7
      for (int k = 0; k < 2; k++) begin bw[k] = n_wait[k]; br[k] = n_req[k]; end
      rd_byte(AW'(7), 5);
      chk("gnt_req_cycles",  0, n_req[0] - br[0],  6);
      chk("gnt_req_cycles",  1, n_req[1] - br[1],  6);
      chk("gnt_wait_cycles", 0, n_wait[0] - bw[0], 8);
      chk("gnt_wait_cycles", 1, n_wait[1] - bw[1], 10);
      chk("gnt_din", 0, o_din[0], ram[7]);
      chk("gnt_din", 1, o_din[1], ram[7]);

      // Read at SIZE returns the fill byte without touching RAM
      for (int k = 0; k < 2; k++) begin bw[k] = n_wait[k]; br[k] = n_req[k]; end
      rd_byte(AW'(SZ), 0);
      for (int k = 0; k < 2; k++) begin
         chk("oor_req_cycles",  k, n_req[k] - br[k],  0);
         chk("oor_wait_cycles", k, n_wait[k] - bw[k], 1);
         chk("oor_din",         k, o_din[k], 8'hFF);
         chk("oor_bytes",       k, bd[k], 6);
      end

      // Deselect during LAT, then a fresh upload
      issue(AW'(5), 0);
      upl = 1'b0;
      repeat (3) step();
      upl = 1'b1;
      step();
      rd_byte(AW'(9), 1);
      for (int k = 0; k < 2; k++) begin
         chk("abort_din",   k, o_din[k], ram[9]);
         chk("abort_bytes", k, bd[k], 1);
         chk("abort_cs",    k, cs[k], ram[9]);
      end

      // Asynchronous reset while waiting for grant
      strobe_only(AW'(3), 10);
      #1 reset = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("async_rst_req",  k, o_req[k],  0);
         chk("async_rst_wait", k, o_wait[k], 0);
         chk("async_rst_din",  k, o_din[k],  8'hFF);
         chk("async_rst_madr", k, o_madr[k], 0);
         chk("async_rst_act",  k, act[k],    0);
      end
      step();
      reset = 1'b0;
      step();
      rd_byte(AW'(2), 0);
      for (int k = 0; k < 2; k++) begin
         chk("post_rst_din",   k, o_din[k], 8'h33);
         chk("post_rst_bytes", k, bd[k], 1);
      end

      // Long upload drives bytes_done into saturation
      for (int i = 0; i < 36; i++) rd_byte(AW'($urandom_range(0, 31)), $urandom_range(0, 3));
      for (int k = 0; k < 2; k++) chk("sat_bytes", k, bd[k], SAT);

      // Random reads with occasional deselects and idle gaps
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            if ($urandom_range(0, 1) == 0) upl = 1'b0;
            else                           idx = 8'($urandom_range(0, 3));
            repeat ($urandom_range(1, 3)) step();
            upl = 1'b1;
            idx = IDX;
            step();
         end
         rd_byte(AW'($urandom_range(0, 31)), $urandom_range(0, 4));
         repeat ($urandom_range(0, 2)) begin
            gnt = 1'($urandom);
            step();
         end
      end
      step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
